icache_direct: RTL

- Direct-mapped, one-word-per-block instruction cache between the fetch stage and the memory arbiter.
- Serves the fetch-stage PC lookup and produces ihit and the instruction word.
- ihit is consumed by the pipeline hazard unit to decide fetch-latch write enables.
- On a miss, fetches the word from memory through the arbiter's instruction port, then fills the frame.

---
 rtl/icache_direct.sv | 103 ++++++++++
 1 files changed

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache.
// Serves fetch-stage lookups and fills misses through the arbiter port.
module icache_direct #(
  parameter int NSETS  = 16,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              halt,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t state, next_state;

  logic [WORD_W-1:0] miss_addr;
  logic [NSETS-1:0]  valid;
  logic [TAG_W-1:0]  tags [NSETS];
  logic [WORD_W-1:0] data [NSETS];

  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             match;
  logic             fill;
  logic             start;

  assign index    = imemaddr[IDX_W+1:2];
  assign tag      = imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx = miss_addr[IDX_W+1:2];
  assign fill_tag = miss_addr[WORD_W-1:IDX_W+2];
  assign match    = valid[index] && (tags[index] == tag);

  always_comb begin
    next_state = state;
    ihit       = 1'b0;
    imemload   = '0;
    iREN       = 1'b0;
    iaddr      = '0;
    fill       = 1'b0;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        ihit = imemREN && match;
        if (ihit) imemload = data[index];
        if (imemREN && !match && !halt) begin
          start      = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        // fill runs to completion even if the PC is redirected
        iREN  = 1'b1;
        iaddr = miss_addr;
        if (!iwait) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (start) miss_addr <= imemaddr & ~WORD_W'(3);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < NSETS; i++) begin
        tags[i] <= '0;
        data[i] <= '0;
      end
    end else if (fill) begin
      valid[fill_idx] <= 1'b1;
      tags[fill_idx]  <= fill_tag;
      data[fill_idx]  <= iload;
    end
  end

endmodule
